seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, 8, max pattern length in bits (2..15).
REQ-002 SHALL have parameter FRM_W, 16, frame-length counter width.
REQ-003 SHALL have parameter CNT_W, 8, match-counter width.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port cfg_we  in  1  pattern/length write strobe.
REQ-007 SHALL have port cfg_pattern  in  PAT_W  pattern; bit 0 = newest bit, bit len-1 = oldest.
REQ-008 SHALL have port cfg_len  in  4  pattern length, legal 1..PAT_W.
REQ-009 SHALL have port start  in  1  single-cycle scan start request.
REQ-010 SHALL have port frame_len  in  FRM_W  number of bits to scan, sampled on accepted start.
REQ-011 SHALL have port in_valid  in  1  serial bit valid.
REQ-012 SHALL have port in_bit  in  1  serial data bit.
REQ-013 SHALL have port in_ready  out  1  bit accepted when in_valid & in_ready.
REQ-014 SHALL have port match  out  1  one-cycle match pulse.
REQ-015 SHALL have port match_cnt  out  CNT_W  matches in current/last frame.
REQ-016 SHALL have port busy  out  1  high in RUN or DONE.
REQ-017 SHALL have port done  out  1  one-cycle end-of-frame pulse.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DONE; IDLE: start & frame_len!=0 -> RUN; start & frame_len==0 -> DONE; RUN: last bit accepted -> DONE; DONE -> IDLE unconditionally.
REQ-019 SHALL, on accepted start, clear bit history, bits-seen counter and match_cnt, and load remaining-bits counter with frame_len.
REQ-020 SHALL drive in_ready = (state==RUN), combinationally from state only.
REQ-021 SHALL, per accepted bit, shift in_bit into PAT_W-bit history at bit 0, increment saturating bits-seen, decrement remaining-bits.
REQ-022 SHALL flag a match when bits-seen (including current bit) >= len and the low len bits of updated history equal the low len bits of the stored pattern.
REQ-023 SHALL register match: pulse high exactly the cycle after the accepting edge; match_cnt updates on the same edge, saturating at 2^CNT_W-1.
REQ-024 SHALL assert done for the single cycle in DONE; match for the final bit coincides with done; match_cnt holds its value until next accepted start.
REQ-025 SHALL ignore start while busy, and ignore in_valid outside RUN; in_valid low stalls without state change.
REQ-026 SHALL accept cfg_we only in IDLE with 1<=cfg_len<=PAT_W; otherwise stored pattern/len unchanged.
REQ-027 SHALL, if cfg_we and start coincide in IDLE, apply the new config before the scan's first bit.

Reset
REQ-028 SHALL on reset (any state, mid-frame included) force IDLE, in_ready=0, match=0, done=0, busy=0, match_cnt=0, history/counters=0, pattern=...0101, len=3 (default "101").
REQ-029 SHALL give reset priority over start, cfg_we and in_valid in the same cycle.

Configuration
REQ-030 SHALL, when SEQ_SCAN_NONOVERLAP_EN is defined, clear history and bits-seen on every match so matches cannot share bits.
REQ-031 SHALL, when SEQ_SCAN_NONOVERLAP_EN is undefined, detect overlapping matches (history retained after match).

Verification
REQ-032 SHALL check: defaults, frame_len=5, bits 1,0,1,0,1 -> match after bits 3 and 5, match_cnt=2, done with 5th-bit match; with SEQ_SCAN_NONOVERLAP_EN -> one match, match_cnt=1.
REQ-033 SHALL check: cfg pattern 8'hF0 len 8, frame_len=10, bits 0,1,1,1,1,0,0,0,0,1 -> single match after bit 9, match_cnt=1.
REQ-034 SHALL check: in_valid gaps of 3 cycles plus start and cfg_we pulses during RUN -> results identical to no-gap run, config unchanged.
REQ-035 SHALL check: pattern 1 len 1, frame_len=300 all ones -> match_cnt saturates at 255; frame_len=0 -> done one cycle after start, match_cnt=0.
REQ-036 SHALL check: reset after 2 bits of a frame -> next cycle in_ready=0, busy=0, match_cnt=0, len=3, pattern 101 restored.
REQ-037 SHALL check: cfg_len=0 and cfg_len=9 writes -> ignored, prior pattern still detected.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: counts matches of a configurable bit pattern across a framed bit stream.
// Optional SEQ_SCAN_NONOVERLAP_EN: matches consume their bits (history cleared on every match).
module seq_scan_ctrl #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned FRM_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             start,
    input  logic [FRM_W-1:0] frame_len,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SEEN_W = 4;
    localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(32'h5555_5555);
    localparam logic [3:0]       LEN_RST = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [PAT_W-1:0]    pattern_q;
    logic [3:0]          len_q;
    logic [PAT_W-1:0]    hist_q;
    logic [SEEN_W-1:0]   seen_q;
    logic [FRM_W-1:0]    remain_q;

    logic                accept;
    logic                cfg_ok;
    logic [PAT_W-1:0]    hist_next;
    logic [SEEN_W-1:0]   seen_next;
    logic [PAT_W-1:0]    len_mask;
    logic                hit;

    // Handshake and status flags derive purely from the state register.
    assign in_ready = (state == RUN);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    assign accept = (state == RUN) && in_valid;
    assign cfg_ok = cfg_we && (state == IDLE) && (cfg_len != 4'd0)
                    && (32'(cfg_len) <= PAT_W);

    // Candidate history after the current bit and its comparison against the pattern.
    always_comb begin
        hist_next = {hist_q[PAT_W-2:0], in_bit};
        seen_next = (seen_q == '1) ? seen_q : seen_q + SEEN_W'(1);
        len_mask  = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
        hit = (seen_next >= len_q) && (((hist_next ^ pattern_q) & len_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pattern_q <= PAT_RST;
            len_q     <= LEN_RST;
            hist_q    <= '0;
            seen_q    <= '0;
            remain_q  <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= 1'b0;

            // Config lands on the start edge too, so it is in place before bit 0.
            if (cfg_ok) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        hist_q    <= '0;
                        seen_q    <= '0;
                        match_cnt <= '0;
                        remain_q  <= frame_len;
                        state     <= (frame_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        hist_q   <= hist_next;
                        seen_q   <= seen_next;
                        remain_q <= remain_q - FRM_W'(1);
                        if (hit) begin
                            match     <= 1'b1;
                            match_cnt <= (match_cnt == '1) ? match_cnt
                                                           : match_cnt + CNT_W'(1);
`ifdef SEQ_SCAN_NONOVERLAP_EN
                            hist_q <= '0;
                            seen_q <= '0;
`else
                            hist_q <= hist_next;
                            seen_q <= seen_next;
`endif
                        end
                        if (remain_q == FRM_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl; expectations are hand-derived (define SEQ_SCAN_NONOVERLAP_EN to match that build).
module tb_seq_scan_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned FRM_W = 16;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [3:0]       cfg_len;
    logic             start;
    logic [FRM_W-1:0] frame_len;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;
    logic             done;

    int tests_run;
    int tests_failed;

    seq_scan_ctrl #(
        .PAT_W(PAT_W),
        .FRM_W(FRM_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .start       (start),
        .frame_len   (frame_len),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame; inputs change and outputs are sampled on the falling edge.
    task automatic run_frame(
        input  logic [299:0] bits,
        input  int           n,
        input  int           gap,
        input  bit           chaos,
        input  bit           cfg_at_start,
        input  logic [7:0]   cpat,
        input  logic [3:0]   clen,
        output logic [31:0]  mmask,
        output logic [7:0]   cnt_at_done,
        output logic         done_at_end,
        output logic         match_at_end,
        output logic         ready_ok
    );
        mmask    = '0;
        ready_ok = 1'b1;
        @(negedge clk);
        start     = 1'b1;
        frame_len = FRM_W'(n);
        if (cfg_at_start) begin
            cfg_we      = 1'b1;
            cfg_pattern = cpat;
            cfg_len     = clen;
        end
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                if (chaos && g == 1) begin
                    start       = 1'b1;
                    frame_len   = FRM_W'(7);
                    cfg_we      = 1'b1;
                    cfg_pattern = 8'h00;
                    cfg_len     = 4'd2;
                end
                @(negedge clk);
                start  = 1'b0;
                cfg_we = 1'b0;
            end
            if (!in_ready || !busy) ready_ok = 1'b0;
            in_valid = 1'b1;
            in_bit   = bits[i];
            @(negedge clk);
            in_valid = 1'b0;
            if (i < 32) mmask[i] = match;
        end
        done_at_end  = done;
        match_at_end = match;
        cnt_at_done  = match_cnt;
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    logic [31:0] mm;
    logic [7:0]  cnt;
    logic        de;
    logic        me;
    logic        rok;
    logic [31:0] exp_mask_101;
    logic [7:0]  exp_cnt_101;
    logic        exp_me_101;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        cfg_we       = 1'b0;
        cfg_pattern  = '0;
        cfg_len      = '0;
        start        = 1'b0;
        frame_len    = '0;
        in_valid     = 1'b0;
        in_bit       = 1'b0;
`ifdef SEQ_SCAN_NONOVERLAP_EN
        exp_mask_101 = 32'h0000_0004;
        exp_cnt_101  = 8'd1;
        exp_me_101   = 1'b0;
`else
        exp_mask_101 = 32'h0000_0014;
        exp_cnt_101  = 8'd2;
        exp_me_101   = 1'b1;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_match", 32'(match), 32'd0);
        check_eq("rst_match_cnt", 32'(match_cnt), 32'd0);

        // Default pattern 101, bits 1,0,1,0,1.
        run_frame(300'b10101, 5, 0, 1'b0, 1'b0, 8'h00, 4'd0, mm, cnt, de, me, rok);
        check_eq("def_mask", mm, exp_mask_101);
        check_eq("def_cnt", 32'(cnt), 32'(exp_cnt_101));
        check_eq("def_done", 32'(de), 32'd1);
        check_eq("def_match_at_done", 32'(me), 32'(exp_me_101));
        check_eq("def_ready", 32'(rok), 32'd1);
        check_eq("def_idle_busy", 32'(busy), 32'd0);
        check_eq("def_cnt_hold", 32'(match_cnt), 32'(exp_cnt_101));

        // Same frame with 3-cycle gaps and ignored start/cfg pulses mid-frame.
        run_frame(300'b10101, 5, 3, 1'b1, 1'b0, 8'h00, 4'd0, mm, cnt, de, me, rok);
        check_eq("gap_mask", mm, exp_mask_101);
        check_eq("gap_cnt", 32'(cnt), 32'(exp_cnt_101));
        check_eq("gap_done", 32'(de), 32'd1);
        check_eq("gap_match_at_done", 32'(me), 32'(exp_me_101));
        check_eq("gap_idle_busy", 32'(busy), 32'd0);

        // Pattern F0 len 8, bits 0,1,1,1,1,0,0,0,0,1.
        cfg_write(8'hF0, 4'd8);
        run_frame(300'b1000011110, 10, 0, 1'b0, 1'b0, 8'h00, 4'd0, mm, cnt, de, me, rok);
        check_eq("f0_mask", mm, 32'h0000_0100);
        check_eq("f0_cnt", 32'(cnt), 32'd1);
        check_eq("f0_done", 32'(de), 32'd1);
        check_eq("f0_match_at_done", 32'(me), 32'd0);

        // Illegal lengths are dropped; F0 must still be the active pattern.
        cfg_write(8'h0F, 4'd0);
        cfg_write(8'h0F, 4'd9);
        run_frame(300'b1000011110, 10, 0, 1'b0, 1'b0, 8'h00, 4'd0, mm, cnt, de, me, rok);
        check_eq("badcfg_mask", mm, 32'h0000_0100);
        check_eq("badcfg_cnt", 32'(cnt), 32'd1);

        // Config written together with start; 300 ones saturate the counter.
        run_frame('1, 300, 0, 1'b0, 1'b1, 8'h01, 4'd1, mm, cnt, de, me, rok);
        check_eq("sat_mask", mm, 32'hFFFF_FFFF);
        check_eq("sat_cnt", 32'(cnt), 32'd255);
        check_eq("sat_done", 32'(de), 32'd1);
        check_eq("sat_match_at_done", 32'(me), 32'd1);

        // Zero-length frame: done one cycle after start, counter cleared.
        run_frame('0, 0, 0, 1'b0, 1'b0, 8'h00, 4'd0, mm, cnt, de, me, rok);
        check_eq("zero_done", 32'(de), 32'd1);
        check_eq("zero_cnt", 32'(cnt), 32'd0);
        check_eq("zero_match", 32'(me), 32'd0);
        check_eq("zero_idle_busy", 32'(busy), 32'd0);

        // Reset two bits into a frame.
        @(negedge clk);
        start     = 1'b1;
        frame_len = FRM_W'(5);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            @(negedge clk);
        end
        check_eq("pre_rst_cnt", 32'(match_cnt), 32'd2);
        in_valid = 1'b1;
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_len  = 4'd1;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        cfg_we   = 1'b0;
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_cnt", 32'(match_cnt), 32'd0);
        check_eq("mid_rst_match", 32'(match), 32'd0);

        // Default 101 pattern is back in force.
        run_frame(300'b10101, 5, 0, 1'b0, 1'b0, 8'h00, 4'd0, mm, cnt, de, me, rok);
        check_eq("post_rst_mask", mm, exp_mask_101);
        check_eq("post_rst_cnt", 32'(cnt), 32'(exp_cnt_101));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
